// File: rtl/sil9011_i2c_pkg.sv
// Shared types and constants for the SIL9011 control-port I2C responder.
package sil9011_i2c_pkg;

    // Protocol phases of the responder; ACK states cover the 9th SCL clock.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic [6:0] SIL9011_DEV_ADDR = 7'h18;
    localparam logic       I2C_WR           = 1'b0;
    localparam logic       I2C_RD           = 1'b1;
    localparam int         REG_COUNT        = 256;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one open-drain I2C line: 2-flop synchronizer, a hold-time
// glitch filter and single-cycle rise/fall pulses on the filtered level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;

    // Synchronize the pad, then accept a new level only after it has been
    // seen for FILTER_LEN consecutive clocks; idle bus level is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/sil9011_i2c_responder.sv
// I2C target model of the SIL9011 control port: a 256 x 8 register file
// reachable through register writes and random/sequential reads.
module sil9011_i2c_responder
    import sil9011_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = SIL9011_DEV_ADDR,
    parameter int         FILTER_LEN = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic       REG_WR_STROBE,
    output logic [7:0] REG_WR_ADDR,
    output logic [7:0] REG_WR_DATA,
    output logic       BUSY,
    input  logic [7:0] DBG_ADDR,
    output logic [7:0] DBG_DATA
);

    // Write-commit interface: REG_WR_STROBE is a one-CLK valid pulse with no
    // ready; REG_WR_ADDR/REG_WR_DATA are stable while it is high and the
    // register file takes the value on the clock edge that ends the pulse.

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       strobe_q, strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [REG_COUNT];

    logic [7:0] byte_in;
    logic [7:0] rd_byte;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i  (CLK),
        .rst_i  (RST),
        .line_i (SCL_IN),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i  (CLK),
        .rst_i  (RST),
        .line_i (SDA_IN),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shift_q[6:0], sda_lvl};
    assign rd_byte   = regs_q[ptr_q];

    // Next-state logic: START/STOP override everything, otherwise bits are
    // sampled on SCL rise and SDA_OE only moves on SCL fall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (start_det) begin
            state_d = ST_DEV_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            state_d = (byte_in[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            ptr_d   = byte_in;
                            state_d = ST_REG_ACK;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 4'd7) begin
                            cnt_d     = 4'd0;
                            strobe_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = byte_in;
                            state_d   = ST_WR_ACK;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                // cnt 0: waiting for the fall that starts ACK; cnt 1: 9th rise seen.
                ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall && cnt_q == 4'd0) begin
                        oe_d = 1'b1;
                    end else if (scl_rise) begin
                        cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d = 4'd0;
                        oe_d  = 1'b0;
                        if (state_q == ST_DEV_ACK) begin
                            if (shift_q[0] == I2C_WR) begin
                                state_d = ST_REG_ADDR;
                            end else begin
                                state_d = ST_RD_DATA;
                                shift_d = rd_byte;
                                oe_d    = ~rd_byte[7];
                            end
                        end else if (state_q == ST_REG_ACK) begin
                            state_d = ST_WR_DATA;
                        end else begin
                            ptr_d   = ptr_q + 8'd1;
                            state_d = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d   = 4'd0;
                            oe_d    = 1'b0;
                            ptr_d   = ptr_q + 8'd1;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = ST_IGNORE;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_RD_DATA;
                        shift_d = rd_byte;
                        oe_d    = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Protocol state registers; reset aborts any transfer and releases SDA.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 8'h00;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file, written from the committed strobe so it lands one CLK later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (strobe_q) begin
            regs_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign SDA_OE        = oe_q;
    assign REG_WR_STROBE = strobe_q;
    assign REG_WR_ADDR   = wr_addr_q;
    assign REG_WR_DATA   = wr_data_q;
    assign BUSY          = busy_q;
    assign DBG_DATA      = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_sil9011_i2c_responder.sv
// Directed bench for the SIL9011 I2C responder: a bit-banged initiator,
// a write-strobe scoreboard and debug-port register checks.
module tb_sil9011_i2c_responder;

    localparam int Q = 8;  // CLKs per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] dbg_addr = 8'h00;

    logic       sda_oe;
    logic       strobe;
    logic       busy;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] dbg_data;
    logic       sda_line;

    int   n_total  = 0;
    int   n_bad    = 0;
    int   n_strobe = 0;
    bit   oe_seen  = 1'b0;
    logic [15:0] exp_q[$];

    assign sda_line = sda_m & ~sda_oe;

    sil9011_i2c_responder dut (
        .CLK          (clk),
        .RST          (rst),
        .SCL_IN       (scl_m),
        .SDA_IN       (sda_line),
        .SDA_OE       (sda_oe),
        .REG_WR_STROBE(strobe),
        .REG_WR_ADDR  (wr_addr),
        .REG_WR_DATA  (wr_data),
        .BUSY         (busy),
        .DBG_ADDR     (dbg_addr),
        .DBG_DATA     (dbg_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every strobe must match the next expected {addr, data}
    always @(negedge clk) begin : strobe_mon
        logic [16:0] e;
        if (!rst && strobe) begin
            n_strobe++;
            e = 17'h0;
            if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
            check_eq("strobe", {1'b1, wr_addr, wr_data}, e);
        end
    end

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
    end

    // driver tasks
    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq(); wq();
            scl_m = 1'b0; wq();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        send_bits(b, 8);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = (sda_line == 1'b0);
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic send_ck(input logic [7:0] b, input bit exp_ack, input string tag);
        bit a;
        write_byte(b, a);
        check_eq(tag, a, exp_ack);
    endtask

    task automatic read_byte(input bit ack_m, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            b[i] = sda_line;
            wq();
            scl_m = 1'b0; wq();
        end
        sda_m = ack_m ? 1'b0 : 1'b1; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic dbg_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        dbg_addr = a;
        #1;
        check_eq(tag, dbg_data, exp);
    endtask

    initial begin
        logic [7:0] rb;
        int base;

        // reset state
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst sda_oe", sda_oe, 0);
        check_eq("rst strobe", strobe, 0);
        check_eq("rst wr_addr", wr_addr, 8'h00);
        check_eq("rst wr_data", wr_data, 8'h00);
        check_eq("rst busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        dbg_check("rst reg05", 8'h05, 8'h00);

        // single write 30 05 10
        base = n_strobe;
        i2c_start();
        send_ck(8'h30, 1'b1, "w1 ack dev");
        check_eq("w1 busy", busy, 1);
        send_ck(8'h05, 1'b1, "w1 ack reg");
        exp_q.push_back({8'h05, 8'h10});
        send_ck(8'h10, 1'b1, "w1 ack data");
        i2c_stop();
        check_eq("w1 busy after stop", busy, 0);
        check_eq("w1 strobes", n_strobe - base, 1);
        dbg_check("w1 reg05", 8'h05, 8'h10);

        // sequential write 30 08 05 01, then read back 2 bytes
        base = n_strobe;
        i2c_start();
        send_ck(8'h30, 1'b1, "w2 ack dev");
        send_ck(8'h08, 1'b1, "w2 ack reg");
        exp_q.push_back({8'h08, 8'h05});
        send_ck(8'h05, 1'b1, "w2 ack d0");
        exp_q.push_back({8'h09, 8'h01});
        send_ck(8'h01, 1'b1, "w2 ack d1");
        i2c_stop();
        check_eq("w2 strobes", n_strobe - base, 2);
        dbg_check("w2 reg09", 8'h09, 8'h01);
        i2c_start();
        send_ck(8'h30, 1'b1, "r2 ack dev");
        send_ck(8'h08, 1'b1, "r2 ack reg");
        i2c_start();
        send_ck(8'h31, 1'b1, "r2 ack rd");
        read_byte(1'b1, rb);
        check_eq("r2 byte0", rb, 8'h05);
        read_byte(1'b0, rb);
        check_eq("r2 byte1", rb, 8'h01);
        check_eq("r2 released", sda_oe, 0);
        i2c_stop();

        // pointer wrap: 30 FF AA BB
        base = n_strobe;
        i2c_start();
        send_ck(8'h30, 1'b1, "wr ack dev");
        send_ck(8'hFF, 1'b1, "wr ack reg");
        exp_q.push_back({8'hFF, 8'hAA});
        send_ck(8'hAA, 1'b1, "wr ack d0");
        exp_q.push_back({8'h00, 8'hBB});
        send_ck(8'hBB, 1'b1, "wr ack d1");
        i2c_stop();
        check_eq("wr strobes", n_strobe - base, 2);
        dbg_check("wr regFF", 8'hFF, 8'hAA);
        dbg_check("wr reg00", 8'h00, 8'hBB);
        i2c_start();
        send_ck(8'h30, 1'b1, "rr ack dev");
        send_ck(8'hFF, 1'b1, "rr ack reg");
        i2c_start();
        send_ck(8'h31, 1'b1, "rr ack rd");
        read_byte(1'b1, rb);
        check_eq("rr byte0", rb, 8'hAA);
        read_byte(1'b0, rb);
        check_eq("rr byte1", rb, 8'hBB);
        i2c_stop();

        // address mismatch 32 05 77
        base = n_strobe;
        oe_seen = 1'b0;
        i2c_start();
        send_ck(8'h32, 1'b0, "mm ack dev");
        send_ck(8'h05, 1'b0, "mm ack reg");
        send_ck(8'h77, 1'b0, "mm ack data");
        check_eq("mm busy", busy, 1);
        check_eq("mm oe seen", oe_seen, 0);
        i2c_stop();
        check_eq("mm busy after stop", busy, 0);
        check_eq("mm strobes", n_strobe - base, 0);
        dbg_check("mm reg05", 8'h05, 8'h10);

        // START inside a data byte: partial byte dropped, pointer kept
        base = n_strobe;
        i2c_start();
        send_ck(8'h30, 1'b1, "pb ack dev");
        send_ck(8'h07, 1'b1, "pb ack reg");
        send_bits(8'hFF, 3);
        i2c_start();
        send_ck(8'h31, 1'b1, "pb ack rd");
        read_byte(1'b0, rb);
        check_eq("pb read reg07", rb, 8'h00);
        i2c_stop();
        check_eq("pb strobes", n_strobe - base, 0);

        // 2-CLK SDA glitch while SCL high is not a START
        @(negedge clk);
        sda_m = 1'b0;
        repeat (2) @(negedge clk);
        sda_m = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("glitch busy", busy, 0);

        // reset during WR_DATA bit 4 of 30 05 E9
        base = n_strobe;
        i2c_start();
        send_ck(8'h30, 1'b1, "ab ack dev");
        send_ck(8'h05, 1'b1, "ab ack reg");
        send_bits(8'hE9, 4);
        sda_m = 1'b1; wq();
        rst = 1'b1;
        @(negedge clk);
        check_eq("ab sda_oe", sda_oe, 0);
        check_eq("ab busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        i2c_stop();
        check_eq("ab strobes", n_strobe - base, 0);
        dbg_check("ab reg05", 8'h05, 8'h00);
        dbg_check("ab regFF", 8'hFF, 8'h00);

        // normal transfer after the abort
        base = n_strobe;
        i2c_start();
        send_ck(8'h30, 1'b1, "fw ack dev");
        send_ck(8'h06, 1'b1, "fw ack reg");
        exp_q.push_back({8'h06, 8'h5A});
        send_ck(8'h5A, 1'b1, "fw ack data");
        i2c_stop();
        check_eq("fw strobes", n_strobe - base, 1);
        dbg_check("fw reg06", 8'h06, 8'h5A);
        i2c_start();
        send_ck(8'h30, 1'b1, "fr ack dev");
        send_ck(8'h06, 1'b1, "fr ack reg");
        i2c_start();
        send_ck(8'h31, 1'b1, "fr ack rd");
        read_byte(1'b0, rb);
        check_eq("fr byte0", rb, 8'h5A);
        i2c_stop();

        // final report
        repeat (10) @(negedge clk);
        check_eq("exp_q drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
